// File: rtl/led_owner_scheduler_pkg.sv
// rtl/led_owner_scheduler_pkg.sv - shared types, grant constants and arbitration helpers
package led_owner_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_GRANT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_0    = 3'b001;
    localparam logic [2:0] GNT_1    = 3'b010;
    localparam logic [2:0] GNT_2    = 3'b100;

    localparam int DEFAULT_TICK_CYCLES = 100_000_000;

    // Round-robin pick: last+1 first, last itself only when nobody else asks.
    function automatic logic [1:0] next_owner(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] cand;
        next_owner = last;
        for (int k = 3; k >= 1; k--) begin
            cand = 2'((int'(last) + k) % 3);
            if (req[cand]) next_owner = cand;
        end
    endfunction

    function automatic logic [2:0] owner_gnt(input logic [1:0] idx);
        case (idx)
            2'd0:    owner_gnt = GNT_0;
            2'd1:    owner_gnt = GNT_1;
            default: owner_gnt = GNT_2;
        endcase
    endfunction

endpackage

// File: rtl/led_owner_scheduler_sec_tick_gen.sv
// rtl/led_owner_scheduler_sec_tick_gen.sv - 1 s prescaler with enable and synchronous clear
module sec_tick_gen
    import led_owner_scheduler_pkg::*;
#(
    parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/led_owner_scheduler.sv
// rtl/led_owner_scheduler.sv - round-robin time-sharing of the LED bank among three pattern sources
module led_owner_scheduler
    import led_owner_scheduler_pkg::*;
#(
    parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int HOLD_SEC    = 2,
    parameter int MAX_SEC     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] req,
    input  logic [2:0] rel,
    input  logic [3:0] pat0,
    input  logic [3:0] pat1,
    input  logic [3:0] pat2,
    output logic [2:0] gnt,
    output logic [3:0] light,
    output logic [3:0] sec_cnt,
    output logic       busy
);

    localparam logic [3:0] HOLD   = 4'(HOLD_SEC);
    localparam logic [3:0] MAX    = 4'(MAX_SEC);
    localparam logic [3:0] MAX_M1 = 4'(MAX_SEC - 1);

    state_t     state;
    logic [1:0] last;
    logic       rel_pend;
    logic       tick;
    logic       tick_en;
    logic       tick_clr;
    logic       rel_hit;
    logic       release_ok;
    logic       timeout;
    logic       exit_grant;

    // During GRANT, last holds the current owner's index.
    assign rel_hit    = rel[last] | ~req[last];
    assign release_ok = (rel_pend | rel_hit) && (sec_cnt >= HOLD);
    assign timeout    = tick && (sec_cnt >= MAX_M1);
    assign exit_grant = (state == S_GRANT) && (release_ok || timeout);

    // Counter only runs in GRANT/GAP and restarts on every state entry.
    assign tick_en  = (state == S_GRANT) || (state == S_GAP);
    assign tick_clr = !tick_en || exit_grant || !start;

    assign busy = (state != S_IDLE);

    sec_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        light = 4'b0000;
        case (gnt)
            GNT_0:   light = pat0;
            GNT_1:   light = pat1;
            GNT_2:   light = pat2;
            default: light = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            gnt      <= GNT_NONE;
            sec_cnt  <= 4'd0;
            last     <= 2'd2;
            rel_pend <= 1'b0;
        end else if (!start) begin
            state    <= S_IDLE;
            gnt      <= GNT_NONE;
            sec_cnt  <= 4'd0;
            rel_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    gnt      <= GNT_NONE;
                    sec_cnt  <= 4'd0;
                    rel_pend <= 1'b0;
                    if (|req) state <= S_ARB;
                end
                S_ARB: begin
                    if (|req) begin
                        gnt   <= owner_gnt(next_owner(req, last));
                        last  <= next_owner(req, last);
                        state <= S_GRANT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (exit_grant) begin
                        state    <= S_GAP;
                        gnt      <= GNT_NONE;
                        sec_cnt  <= 4'd0;
                        rel_pend <= 1'b0;
                    end else begin
                        if (tick && (sec_cnt < MAX)) sec_cnt <= sec_cnt + 4'd1;
                        if (rel_hit) rel_pend <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (tick) state <= (|req) ? S_ARB : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_owner_scheduler.sv
// tb/tb_led_owner_scheduler.sv - scoreboard bench for led_owner_scheduler
module tb_led_owner_scheduler;

    typedef struct {
        logic [2:0] gnt;
        logic [3:0] light;
        int         cyc;
    } exp_t;

    localparam logic [3:0] P0 = 4'b1010;
    localparam logic [3:0] P1 = 4'b0110;
    localparam logic [3:0] P2 = 4'b1100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] rel = 3'b000;
    logic [3:0] pat0 = 4'b0000;
    logic [3:0] pat1 = 4'b0000;
    logic [3:0] pat2 = 4'b0000;
    logic [2:0] gnt;
    logic [3:0] light;
    logic [3:0] sec_cnt;
    logic       busy;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] prev_gnt = 3'b000;
    exp_t       sb[$];

    led_owner_scheduler #(
        .TICK_CYCLES(10),
        .HOLD_SEC   (2),
        .MAX_SEC    (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .req    (req),
        .rel    (rel),
        .pat0   (pat0),
        .pat1   (pat1),
        .pat2   (pat2),
        .gnt    (gnt),
        .light  (light),
        .sec_cnt(sec_cnt),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic expect_evt(input logic [2:0] g, input logic [3:0] l, input int c);
        exp_t e;
        e.gnt = g;
        e.light = l;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Every change of gnt must match the next expected grant event.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (gnt !== prev_gnt) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_gnt: got gnt=%b at cycle %0d expected no change", gnt, cyc);
                end else begin
                    e = sb.pop_front();
                    if (gnt !== e.gnt || light !== e.light || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL grant_event: got gnt=%b light=%b cycle=%0d expected gnt=%b light=%b cycle=%0d",
                                 gnt, light, cyc, e.gnt, e.light, e.cyc);
                    end
                end
                prev_gnt = gnt;
            end
        end
    endtask

    initial begin
        int c;
        fork
            monitor();
        join_none

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            req   = 3'($urandom);
            rel   = 3'($urandom);
            pat0  = 4'($urandom);
            pat1  = 4'($urandom);
            pat2  = 4'($urandom);
            step(1);
        end
        check("reset_gnt", 8'(gnt), 8'h0);
        check("reset_light", 8'(light), 8'h0);
        check("reset_sec_cnt", 8'(sec_cnt), 8'h0);
        check("reset_busy", 8'(busy), 8'h0);
        start = 1'b0; req = 3'b000; rel = 3'b000;
        pat0 = P0; pat1 = P1; pat2 = P2;
        rst_n = 1'b1;
        step(2);

        // Single requester with early rel held until HOLD_SEC
        c = cyc;
        start = 1'b1; req = 3'b001;
        expect_evt(3'b001, P0, c + 2);
        expect_evt(3'b000, 4'b0000, c + 23);
        expect_evt(3'b001, P0, c + 34);
        expect_evt(3'b000, 4'b0000, c + 41);
        wait_until(c + 5);
        rel = 3'b001;
        step(1);
        rel = 3'b000;
        wait_until(c + 12);
        check("single_sec1", 8'(sec_cnt), 8'd1);
        wait_until(c + 22);
        check("single_sec2", 8'(sec_cnt), 8'd2);
        wait_until(c + 25);
        check("single_gap_light", 8'(light), 8'h0);
        check("single_gap_sec", 8'(sec_cnt), 8'd0);
        wait_until(c + 40);
        start = 1'b0;
        wait_until(c + 41);
        check("single_abort_busy", 8'(busy), 8'h0);
        req = 3'b000;

        // Fresh reset, then three-way round robin with timeouts
        step(1);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        c = cyc;
        start = 1'b1; req = 3'b111;
        expect_evt(3'b001, P0, c + 2);
        expect_evt(3'b000, 4'b0000, c + 42);
        expect_evt(3'b010, P1, c + 53);
        expect_evt(3'b000, 4'b0000, c + 93);
        expect_evt(3'b100, P2, c + 104);
        expect_evt(3'b000, 4'b0000, c + 144);
        expect_evt(3'b001, P0, c + 155);
        expect_evt(3'b000, 4'b0000, c + 160);
        wait_until(c + 41);
        rel = 3'b001;
        step(1);
        rel = 3'b000;
        wait_until(c + 160);
        rst_n = 1'b0;
        #1;
        check("midreset_gnt", 8'(gnt), 8'h0);
        check("midreset_light", 8'(light), 8'h0);
        check("midreset_sec_cnt", 8'(sec_cnt), 8'h0);
        check("midreset_busy", 8'(busy), 8'h0);
        step(2);
        start = 1'b0; req = 3'b000;
        rst_n = 1'b1;
        step(1);

        // Owner 1 withdraws its request at sec_cnt=0
        c = cyc;
        start = 1'b1; req = 3'b110;
        expect_evt(3'b010, P1, c + 2);
        expect_evt(3'b000, 4'b0000, c + 23);
        expect_evt(3'b100, P2, c + 34);
        expect_evt(3'b000, 4'b0000, c + 41);
        wait_until(c + 3);
        check("early_sec0", 8'(sec_cnt), 8'd0);
        req = 3'b100;
        wait_until(c + 22);
        check("early_sec2", 8'(sec_cnt), 8'd2);
        wait_until(c + 40);
        start = 1'b0;
        wait_until(c + 41);
        check("early_abort_busy", 8'(busy), 8'h0);
        check("early_abort_light", 8'(light), 8'h0);

        // Abort during requester 0, then requester 1 wins next
        c = cyc;
        start = 1'b1; req = 3'b001;
        expect_evt(3'b001, P0, c + 2);
        expect_evt(3'b000, 4'b0000, c + 6);
        expect_evt(3'b010, P1, c + 10);
        expect_evt(3'b000, 4'b0000, c + 16);
        wait_until(c + 5);
        start = 1'b0;
        wait_until(c + 6);
        check("abort_busy", 8'(busy), 8'h0);
        check("abort_light", 8'(light), 8'h0);
        wait_until(c + 8);
        start = 1'b1; req = 3'b111;
        wait_until(c + 15);
        start = 1'b0;
        wait_until(c + 16);
        req = 3'b000;
        step(2);

        // Requests vanish during ARB
        c = cyc;
        start = 1'b1; req = 3'b001;
        wait_until(c + 1);
        req = 3'b000;
        check("withdraw_arb_busy", 8'(busy), 8'h1);
        wait_until(c + 2);
        check("withdraw_idle_busy", 8'(busy), 8'h0);
        check("withdraw_gnt", 8'(gnt), 8'h0);
        step(5);

        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
